vga_frame_scanout: RTL



---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_timing_counter.sv | 65 ++++++
 rtl/vga_frame_scanout.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants and scanout types
package vga_timing_pkg;

  // Default 640x480@60 timing
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  // Sync windows are half-open: [start, end)
  localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;

  // Picture placement: 256 source columns doubled to 512 screen columns
  localparam int          X_OFFSET_D   = 64;
  localparam int          SCALED_W     = 512;
  localparam logic [7:0]  BORDER_IDX_D = 8'h0F;

  // Counter width covers 800 columns and 525 lines
  localparam int CNT_W = 10;

  // Per-pixel flags carried from the counter stage to the output stage
  typedef struct packed {
    logic active;
    logic in_window;
    logic hsync_n;
    logic vsync_n;
    logic vblank;
  } scan_flags_t;

  localparam scan_flags_t FLAGS_IDLE = '{
    active: 1'b0, in_window: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, vblank: 1'b0
  };

  // True when lo <= x < hi
  function automatic logic in_span(input logic [CNT_W-1:0] x,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - h/v raster counters, raw sync/active flags, frame_start
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             vblank,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster position advances one pixel per strobe; frame_start marks the (0,0) wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_n = !in_span(h_cnt, HS_START, HS_END);
  assign vsync_n = !in_span(v_cnt, VS_START, VS_END);
  assign vblank  = (v_cnt >= V_ACT);

endmodule

// File: rtl/vga_frame_scanout.sv
// rtl/vga_frame_scanout.sv - frame-buffer read, 2x scale, centring and VGA output alignment
module vga_frame_scanout
  import vga_timing_pkg::*;
#(
  parameter int         H_ACTIVE   = H_ACTIVE_D,
  parameter int         H_FP       = H_FP_D,
  parameter int         H_SYNC     = H_SYNC_D,
  parameter int         H_BP       = H_BP_D,
  parameter int         V_ACTIVE   = V_ACTIVE_D,
  parameter int         V_FP       = V_FP_D,
  parameter int         V_SYNC     = V_SYNC_D,
  parameter int         V_BP       = V_BP_D,
  parameter int         X_OFFSET   = X_OFFSET_D,
  parameter logic [7:0] BORDER_IDX = BORDER_IDX_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [8:0] rd_addr_row,
  output logic [8:0] rd_addr_col,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_de,
  output logic [7:0] vga_color_idx,
  output logic       vblank,
  output logic       frame_start
);

  localparam logic [CNT_W-1:0] WIN_START = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0] WIN_END   = CNT_W'(X_OFFSET + SCALED_W);
  localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             raw_active;
  logic             raw_hsync_n;
  logic             raw_vsync_n;
  logic             raw_vblank;
  logic             in_window;
  logic [8:0]       col_next;
  logic [8:0]       row_next;
  scan_flags_t      s1;
  logic [7:0]       pix_hold;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (raw_active),
    .hsync_n     (raw_hsync_n),
    .vsync_n     (raw_vsync_n),
    .vblank      (raw_vblank),
    .frame_start (frame_start)
  );

  // Each source pixel covers two screen columns and two screen lines
  assign in_window = in_span(h_cnt, WIN_START, WIN_END) && (v_cnt < V_ACT);
  assign col_next  = 9'((h_cnt - WIN_START) >> 1);
  assign row_next  = 9'(v_cnt >> 1);

  // Stage 1: issue the frame-buffer read and capture the flags for this pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= FLAGS_IDLE;
      rd_en       <= 1'b0;
      rd_addr_row <= '0;
      rd_addr_col <= '0;
    end else begin
      rd_en <= pix_en && in_window;
      if (pix_en) begin
        s1.active    <= raw_active;
        s1.in_window <= in_window;
        s1.hsync_n   <= raw_hsync_n;
        s1.vsync_n   <= raw_vsync_n;
        s1.vblank    <= raw_vblank;
        if (in_window) begin
          rd_addr_row <= row_next;
          rd_addr_col <= col_next;
        end
      end
    end
  end

  // Capture the returned pixel one clk after the request, independent of the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_hold <= '0;
    end else if (rd_en) begin
      pix_hold <= rd_data;
    end
  end

  // Stage 2: drive the VGA outputs so sync, enable and colour leave together
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync     <= 1'b1;
      vga_vsync     <= 1'b1;
      vga_de        <= 1'b0;
      vga_color_idx <= '0;
      vblank        <= 1'b0;
    end else if (pix_en) begin
      vga_hsync <= s1.hsync_n;
      vga_vsync <= s1.vsync_n;
      vga_de    <= s1.active;
      vblank    <= s1.vblank;
      if (s1.in_window) begin
        vga_color_idx <= pix_hold;
      end else if (s1.active) begin
        vga_color_idx <= BORDER_IDX;
      end else begin
        vga_color_idx <= '0;
      end
    end
  end

endmodule
